// File: rtl/tarot_pkg.sv
// Shared definitions for the tarot spread sequencer: deck geometry,
// orientation bit position and the sequencer state encoding.
package tarot_pkg;

  localparam int DECK_SIZE = 78;
  localparam int REV_BIT   = 16;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LAUNCH  = 3'd1,
    S_RELEASE = 3'd2,
    S_EVAL    = 3'd3,
    S_EMIT    = 3'd4,
    S_FINISH  = 3'd5
  } state_t;

endpackage

// File: rtl/tarot_card_map.sv
// Combinational card mapping: scales the upper half of a Q1.31 PRNG word
// onto the deck, and finds the lowest card not yet dealt.
module tarot_card_map
  import tarot_pkg::*;
(
  input  logic [15:0]          i_x_hi,
  input  logic [DECK_SIZE-1:0] i_mask,
  output logic [6:0]           o_idx,
  output logic [6:0]           o_free_idx
);

  logic [22:0] w_prod;

  // Scale a 16-bit fraction by the deck size; the integer part is the card.
  always_comb begin
    w_prod = {7'd0, i_x_hi} * 23'd78;
    o_idx  = w_prod[22:16];
  end

  // Lowest clear mask bit; scanning downward lets the lowest index win.
  always_comb begin
    o_free_idx = 7'd0;
    for (int i = DECK_SIZE - 1; i >= 0; i--) begin
      if (!i_mask[i]) begin
        o_free_idx = 7'(i);
      end else begin
        o_free_idx = o_free_idx;
      end
    end
  end

endmodule

// File: rtl/tarot_spread_sequencer.sv
// Deals a spread of distinct tarot cards by sequencing the shared PRNG,
// rejecting duplicates by re-seeding and streaming cards over valid/ready.
module tarot_spread_sequencer
  import tarot_pkg::*;
#(
  parameter int MAX_CARDS      = 10,
  parameter int MAX_RETRY      = 15,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        draw_req,
  input  logic [3:0]  draw_count,
  input  logic [15:0] seed_q16,
  input  logic [31:0] fingerprint_mean,
  output logic        prng_start,
  output logic [15:0] prng_seed_q16,
  output logic [31:0] prng_fingerprint_mean,
  input  logic [31:0] prng_x,
  input  logic [31:0] prng_y,
  input  logic        prng_done,
  output logic        card_valid,
  input  logic        card_ready,
  output logic [6:0]  card_idx,
  output logic        card_reversed,
  output logic [3:0]  card_pos,
  output logic        busy,
  output logic        spread_done,
  output logic        retry_exhausted,
  output logic        prng_timeout
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t               r_state;
  state_t               w_next;
  logic [3:0]           r_count;
  logic [3:0]           r_pos;
  logic [3:0]           r_retry;
  logic [DECK_SIZE-1:0] r_mask;
  logic [15:0]          r_seed;
  logic [31:0]          r_fp;
  logic [15:0]          r_x_hi;
  logic                 r_y_rev;
  logic [TMO_W-1:0]     r_tmo;
  logic [6:0]           r_card_idx;
  logic                 r_card_rev;
  logic                 r_retry_exh;
  logic                 r_timeout;

  logic [6:0]           w_map_idx;
  logic [6:0]           w_free_idx;
  logic [3:0]           w_count_clamp;
  logic [3:0]           w_pos_new;
  logic [3:0]           w_retry_new;
  logic                 w_dup;
  logic                 w_can_retry;
  logic                 w_tmo_hit;

  tarot_card_map u_map (
    .i_x_hi     (r_x_hi),
    .i_mask     (r_mask),
    .o_idx      (w_map_idx),
    .o_free_idx (w_free_idx)
  );

  // Shared decode terms for the FSM and datapath.
  always_comb begin
    w_count_clamp = (draw_count > 4'(MAX_CARDS)) ? 4'(MAX_CARDS) : draw_count;
    w_pos_new     = r_pos + 4'd1;
    w_retry_new   = r_retry + 4'd1;
    w_dup         = r_mask[w_map_idx];
    w_can_retry   = (r_retry < 4'(MAX_RETRY));
    w_tmo_hit     = (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; done takes priority over a coincident timeout.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (draw_req) begin
          w_next = (w_count_clamp == 4'd0) ? S_FINISH : S_LAUNCH;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_LAUNCH: begin
        if (prng_done)      w_next = S_RELEASE;
        else if (w_tmo_hit) w_next = S_FINISH;
        else                w_next = S_LAUNCH;
      end
      S_RELEASE: begin
        if (!prng_done)     w_next = S_EVAL;
        else if (w_tmo_hit) w_next = S_FINISH;
        else                w_next = S_RELEASE;
      end
      S_EVAL: begin
        if (w_dup && w_can_retry) w_next = S_LAUNCH;
        else                      w_next = S_EMIT;
      end
      S_EMIT: begin
        if (card_ready) begin
          w_next = (w_pos_new == r_count) ? S_FINISH : S_LAUNCH;
        end else begin
          w_next = S_EMIT;
        end
      end
      S_FINISH: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Timeout counter runs across LAUNCH and RELEASE of one transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tmo <= '0;
    end else if (r_state == S_LAUNCH || r_state == S_RELEASE) begin
      r_tmo <= r_tmo + TMO_W'(1);
    end else begin
      r_tmo <= '0;
    end
  end

  // Spread datapath: latched request, PRNG capture, dealt mask and card.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count     <= 4'd0;
      r_pos       <= 4'd0;
      r_retry     <= 4'd0;
      r_mask      <= '0;
      r_seed      <= 16'd0;
      r_fp        <= 32'd0;
      r_x_hi      <= 16'd0;
      r_y_rev     <= 1'b0;
      r_card_idx  <= 7'd0;
      r_card_rev  <= 1'b0;
      r_retry_exh <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (draw_req) begin
            r_count     <= w_count_clamp;
            r_fp        <= fingerprint_mean;
            r_seed      <= seed_q16;
            r_mask      <= '0;
            r_pos       <= 4'd0;
            r_retry     <= 4'd0;
            r_retry_exh <= 1'b0;
            r_timeout   <= 1'b0;
          end
        end
        S_LAUNCH: begin
          if (prng_done) begin
            r_x_hi  <= prng_x[31:16];
            r_y_rev <= prng_y[REV_BIT];
          end else if (w_tmo_hit) begin
            r_timeout <= 1'b1;
          end
        end
        S_RELEASE: begin
          if (prng_done && w_tmo_hit) begin
            r_timeout <= 1'b1;
          end
        end
        S_EVAL: begin
          r_card_rev <= r_y_rev;
          if (!w_dup) begin
            r_mask[w_map_idx] <= 1'b1;
            r_card_idx        <= w_map_idx;
          end else if (w_can_retry) begin
            r_retry <= w_retry_new;
            r_seed  <= r_x_hi ^ {12'd0, w_retry_new};
          end else begin
            r_mask[w_free_idx] <= 1'b1;
            r_card_idx         <= w_free_idx;
            r_retry_exh        <= 1'b1;
          end
        end
        S_EMIT: begin
          if (card_ready) begin
            r_pos   <= w_pos_new;
            r_retry <= 4'd0;
            r_seed  <= r_x_hi ^ {12'd0, w_pos_new};
          end
        end
        default: begin
          r_count <= r_count;
        end
      endcase
    end
  end

  // Output decode from the state register and datapath registers.
  always_comb begin
    prng_start            = (r_state == S_LAUNCH);
    card_valid            = (r_state == S_EMIT);
    spread_done           = (r_state == S_FINISH);
    busy                  = (r_state == S_LAUNCH) || (r_state == S_RELEASE) ||
                            (r_state == S_EVAL)   || (r_state == S_EMIT);
    prng_seed_q16         = r_seed;
    prng_fingerprint_mean = r_fp;
    card_idx              = r_card_idx;
    card_reversed         = r_card_rev;
    card_pos              = r_pos;
    retry_exhausted       = r_retry_exh;
    prng_timeout          = r_timeout;
  end

endmodule

// File: tb/tb_tarot_spread_sequencer.sv
// Directed bench for tarot_spread_sequencer with a hand-driven PRNG.
module tb_tarot_spread_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        draw_req = 1'b0;
  logic [3:0]  draw_count = 4'd0;
  logic [15:0] seed_q16 = 16'd0;
  logic [31:0] fingerprint_mean = 32'd0;
  logic        prng_start;
  logic [15:0] prng_seed_q16;
  logic [31:0] prng_fingerprint_mean;
  logic [31:0] prng_x = 32'd0;
  logic [31:0] prng_y = 32'd0;
  logic        prng_done = 1'b0;
  logic        card_valid;
  logic        card_ready = 1'b0;
  logic [6:0]  card_idx;
  logic        card_reversed;
  logic [3:0]  card_pos;
  logic        busy;
  logic        spread_done;
  logic        retry_exhausted;
  logic        prng_timeout;

  int n_cmp = 0;
  int n_err = 0;
  int starts = 0;
  logic prev_start = 1'b0;

  tarot_spread_sequencer #(.MAX_CARDS(10), .MAX_RETRY(2), .TIMEOUT_CYCLES(1024)) dut (
    .clk(clk), .rst(rst), .draw_req(draw_req), .draw_count(draw_count),
    .seed_q16(seed_q16), .fingerprint_mean(fingerprint_mean),
    .prng_start(prng_start), .prng_seed_q16(prng_seed_q16),
    .prng_fingerprint_mean(prng_fingerprint_mean),
    .prng_x(prng_x), .prng_y(prng_y), .prng_done(prng_done),
    .card_valid(card_valid), .card_ready(card_ready), .card_idx(card_idx),
    .card_reversed(card_reversed), .card_pos(card_pos), .busy(busy),
    .spread_done(spread_done), .retry_exhausted(retry_exhausted),
    .prng_timeout(prng_timeout)
  );

  always #5 clk = ~clk;

  // Count PRNG start transactions (rising edges of prng_start).
  always @(posedge clk) begin
    if (prng_start && !prev_start) starts = starts + 1;
    prev_start = prng_start;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic draw(input logic [3:0] cnt, input logic [15:0] seed, input logic [31:0] fp);
    draw_count = cnt;
    seed_q16 = seed;
    fingerprint_mean = fp;
    draw_req = 1'b1;
    step();
    draw_req = 1'b0;
  endtask

  // One PRNG transaction; ends with the DUT in EVAL.
  task automatic do_txn(input string tag, input logic [31:0] x, input logic [31:0] y,
                        input logic [15:0] exp_seed);
    int k;
    k = 0;
    while (!prng_start && k < 20) begin
      step();
      k++;
    end
    chk({tag, "_start"}, {31'd0, prng_start}, 32'd1);
    chk({tag, "_seed"}, {16'd0, prng_seed_q16}, {16'd0, exp_seed});
    prng_x = x;
    prng_y = y;
    prng_done = 1'b1;
    step();
    chk({tag, "_start_drop"}, {31'd0, prng_start}, 32'd0);
    prng_done = 1'b0;
    step();
  endtask

  task automatic take(input string tag, input logic [6:0] idx, input logic rev, input logic [3:0] pos);
    chk({tag, "_valid"}, {31'd0, card_valid}, 32'd1);
    chk({tag, "_idx"}, {25'd0, card_idx}, {25'd0, idx});
    chk({tag, "_rev"}, {31'd0, card_reversed}, {31'd0, rev});
    chk({tag, "_pos"}, {28'd0, card_pos}, {28'd0, pos});
    card_ready = 1'b1;
    step();
    card_ready = 1'b0;
  endtask

  task automatic finish_chk(input string tag);
    chk({tag, "_done"}, {31'd0, spread_done}, 32'd1);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_valid0"}, {31'd0, card_valid}, 32'd0);
    step();
    chk({tag, "_done_pulse"}, {31'd0, spread_done}, 32'd0);
  endtask

  initial begin
    int s0;
    int k;
    logic stable;

    // Reset state
    step(); step();
    chk("rst_start", {31'd0, prng_start}, 32'd0);
    chk("rst_valid", {31'd0, card_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, spread_done}, 32'd0);
    chk("rst_idx", {25'd0, card_idx}, 32'd0);
    chk("rst_seed", {16'd0, prng_seed_q16}, 32'd0);
    chk("rst_flags", {30'd0, retry_exhausted, prng_timeout}, 32'd0);
    rst = 1'b0;
    step();

    // Spread of 3 with mapping corner values
    s0 = starts;
    draw(4'd3, 16'h1234, 32'hCAFE_BABE);
    chk("s3_start_n1", {31'd0, prng_start}, 32'd1);
    chk("s3_busy", {31'd0, busy}, 32'd1);
    chk("s3_fp", prng_fingerprint_mean, 32'hCAFE_BABE);
    do_txn("s3_t0", 32'h8000_0000, 32'h0001_0000, 16'h1234);
    step();
    take("s3_c0", 7'd39, 1'b1, 4'd0);
    do_txn("s3_t1", 32'hFFFF_0000, 32'h0000_0000, 16'h8001);
    step();
    take("s3_c1", 7'd77, 1'b0, 4'd1);
    do_txn("s3_t2", 32'h0000_FFFF, 32'h0000_0000, 16'hFFFD);
    step();
    take("s3_c2", 7'd0, 1'b0, 4'd2);
    finish_chk("s3_fin");
    chk("s3_txns", starts - s0, 32'd3);
    chk("s3_flags", {30'd0, retry_exhausted, prng_timeout}, 32'd0);

    // Duplicate re-draw
    draw(4'd2, 16'h0042, 32'h0000_0001);
    do_txn("dup_t0", 32'h4000_0000, 32'h0000_0000, 16'h0042);
    step();
    take("dup_c0", 7'd19, 1'b0, 4'd0);
    do_txn("dup_t1", 32'h4000_0000, 32'h0000_0000, 16'h4001);
    step();
    chk("dup_relaunch", {31'd0, prng_start}, 32'd1);
    chk("dup_novalid", {31'd0, card_valid}, 32'd0);
    do_txn("dup_t2", 32'hC000_0000, 32'h0000_0000, 16'h4001);
    step();
    take("dup_c1", 7'd58, 1'b0, 4'd1);
    finish_chk("dup_fin");
    chk("dup_noexh", {31'd0, retry_exhausted}, 32'd0);

    // Retry exhaustion with constant x=0
    s0 = starts;
    draw(4'd2, 16'h0007, 32'h0000_0002);
    do_txn("exh_t0", 32'h0, 32'h0, 16'h0007);
    step();
    take("exh_c0", 7'd0, 1'b0, 4'd0);
    do_txn("exh_t1", 32'h0, 32'h0, 16'h0001);
    step();
    do_txn("exh_t2", 32'h0, 32'h0, 16'h0001);
    step();
    do_txn("exh_t3", 32'h0, 32'h0, 16'h0002);
    step();
    chk("exh_flag", {31'd0, retry_exhausted}, 32'd1);
    take("exh_c1", 7'd1, 1'b0, 4'd1);
    finish_chk("exh_fin");
    chk("exh_txns", starts - s0, 32'd4);
    chk("exh_sticky", {31'd0, retry_exhausted}, 32'd1);

    // Zero-card spread clears sticky flags and finishes at once
    draw(4'd0, 16'h0000, 32'h0);
    chk("zero_done", {31'd0, spread_done}, 32'd1);
    chk("zero_start", {31'd0, prng_start}, 32'd0);
    chk("zero_clear", {31'd0, retry_exhausted}, 32'd0);
    step();

    // Backpressure: 20 cycles with card_ready low
    s0 = starts;
    draw(4'd1, 16'h0100, 32'h0);
    do_txn("bp_t0", 32'h8000_0000, 32'h0001_0000, 16'h0100);
    step();
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (!(card_valid && card_idx == 7'd39 && card_reversed && card_pos == 4'd0 && !prng_start))
        stable = 1'b0;
      step();
    end
    chk("bp_stable", {31'd0, stable}, 32'd1);
    chk("bp_txns", starts - s0, 32'd1);
    take("bp_c0", 7'd39, 1'b1, 4'd0);
    finish_chk("bp_fin");

    // PRNG timeout
    draw(4'd2, 16'h0200, 32'h0);
    k = 0;
    stable = 1'b0;
    while (!prng_timeout && k < 1100) begin
      if (card_valid) stable = 1'b1;
      step();
      k++;
    end
    chk("to_cycles", k, 32'd1024);
    chk("to_flag", {31'd0, prng_timeout}, 32'd1);
    chk("to_nocard", {31'd0, stable}, 32'd0);
    finish_chk("to_fin");
    chk("to_sticky", {31'd0, prng_timeout}, 32'd1);

    // Reset mid-LAUNCH, then a fresh spread
    draw(4'd3, 16'hAAAA, 32'h1234_5678);
    step();
    chk("mr_launch", {31'd0, prng_start}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mr_start", {31'd0, prng_start}, 32'd0);
    chk("mr_busy", {31'd0, busy}, 32'd0);
    chk("mr_done", {31'd0, spread_done}, 32'd0);
    chk("mr_seed", {16'd0, prng_seed_q16}, 32'd0);
    chk("mr_fp", prng_fingerprint_mean, 32'd0);
    chk("mr_flags", {30'd0, retry_exhausted, prng_timeout}, 32'd0);
    draw(4'd1, 16'h0300, 32'h0);
    chk("mr_restart", {31'd0, prng_start}, 32'd1);
    do_txn("mr_t0", 32'hFFFF_0000, 32'h0, 16'h0300);
    step();
    take("mr_c0", 7'd77, 1'b0, 4'd0);
    finish_chk("mr_fin");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tarot_spread_sequencer.md
# tarot_spread_sequencer

Controller that sequences the shared Henon PRNG to deal a complete tarot spread of 1–MAX_CARDS distinct cards. It sits between the reading front-end and the PRNG core. It issues one start/done transaction per draw, maps each Q1.31 result onto a 78-card deck with an orientation bit, rejects duplicates by re-seeding, and streams cards out over a valid/ready handshake.

## Interface
- MAX_CARDS, 10: largest spread; draw_count above this is clamped.
- MAX_RETRY, 15: duplicate re-draws allowed per card position.
- TIMEOUT_CYCLES, 1024: cycles allowed for one PRNG transaction.
- clk  in  1  single clock; rising edge.
- rst  in  1  reset; synchronous, active-high.
- draw_req  in  1  start a spread; sampled only in IDLE.
- draw_count  in  4  cards requested; latched with draw_req.
- seed_q16  in  16  initial PRNG seed; latched with draw_req.
- fingerprint_mean  in  32  Q1.31 mean; latched with draw_req; driven constant for the whole spread.
- prng_start  out  1  PRNG start level.
- prng_seed_q16  out  16  seed to PRNG; stable while prng_start=1.
- prng_fingerprint_mean  out  32  latched fingerprint_mean.
- prng_x, prng_y  in  32 each  PRNG results (Q1.31).
- prng_done  in  1  PRNG done level.
- card_valid  out  1  card available.
- card_ready  in  1  consumer accepts.
- card_idx  out  7  card 0–77.
- card_reversed  out  1  orientation.
- card_pos  out  4  spread position, 0-based.
- busy  out  1  spread in progress.
- spread_done  out  1  one-cycle pulse at end of spread.
- retry_exhausted  out  1  sticky per spread; set when a fallback pick occurred.
- prng_timeout  out  1  sticky per spread; set when a PRNG transaction timed out.

## Operation
- States: IDLE, LAUNCH, RELEASE, EVAL, EMIT, FINISH.
- IDLE: on draw_req, latch the inputs and set count = min(draw_count, MAX_CARDS). Clear the drawn mask (78 bits), pos, retry counter and both sticky flags. Set busy. If count=0, go to FINISH; otherwise go to LAUNCH with seed = seed_q16.
- LAUNCH: hold prng_start=1. On prng_done=1, capture prng_x/prng_y, drop start and go to RELEASE. If the timeout counter reaches TIMEOUT_CYCLES, set prng_timeout, drop start and go to FINISH; no further cards are emitted.
- RELEASE: prng_start=0. Wait for prng_done=0; the PRNG clears done only after returning to idle. Then go to EVAL. The timeout counter also applies here.
- EVAL (1 cycle):
  - idx = (x[31:16] × 78) >> 16, which is always in the range 0–77.
  - reversed = y[16].
  - If mask[idx]=0: set the mask bit and go to EMIT.
  - Else, if retry < MAX_RETRY: retry++, next seed = x[31:16] ^ {12'b0, retry[3:0]}, go to LAUNCH.
  - Else: idx = lowest clear mask bit, set retry_exhausted, go to EMIT.
- EMIT: card_valid=1; outputs stay stable until accepted. On card_valid & card_ready: pos++ and retry=0. Next seed = x[31:16] ^ {12'b0, pos_new}. If pos_new=count go to FINISH, else go to LAUNCH.
- FINISH: spread_done=1 for one cycle, busy drops, return to IDLE. The sticky flags hold until the next draw_req.
- draw_req outside IDLE is ignored.

## Timing
- Reset values: all outputs 0, state IDLE, mask cleared. Asserting rst mid-spread aborts the spread with no spread_done. The PRNG shares the same rst.
- draw_req at cycle N → prng_start=1 at N+1.
- prng_done rising seen at cycle M → prng_start=0 at M+1.
- Cycle after prng_done is seen low: EVAL. card_valid is asserted on the following cycle.
- Minimum one idle cycle of prng_start between PRNG transactions, guaranteed by RELEASE.
- Card handshake: transfer occurs on the cycle where card_valid & card_ready are both 1. card_valid never drops without a transfer.
- spread_done is asserted the cycle after the last transfer. busy=0 in the same cycle as spread_done.

## Structure
- Shared package tarot_pkg holds DECK_SIZE=78, the state enum, and the reversal bit position.
- One sub-module, tarot_card_map: combinational 16×7 multiply/shift plus the lowest-clear-bit priority encoder over the 78-bit mask.

## Test plan
- Mapping: prng_x=0x8000_0000 → card_idx=39; prng_x=0xFFFF_0000 → 77; prng_x=0x0000_FFFF → 0. prng_y bit 16 = 1 → reversed=1.
- Spread of 3 with a behavioural PRNG model: exactly 3 start/done transactions, card_pos 0,1,2, one spread_done pulse, busy low afterwards.
- Duplicate: model returns the same x twice → second EVAL re-launches with seed = x[31:16]^1, and the emitted idx differs from the first.
- Exhaustion: MAX_RETRY=2, model returns a constant x=0 → second card has idx=1 and retry_exhausted=1.
- Backpressure plus timeout:
  - Hold card_ready=0 for 20 cycles → card outputs stay stable and no new prng_start is issued.
  - Model that never asserts done → prng_timeout=1 after 1024 cycles, followed by spread_done.
- Reset mid-LAUNCH → all outputs 0 the next cycle; a fresh draw_req then starts normally.
